noc_router_buffered: RTL

Parametrised successor to the 4-port NOC crossbar router. Adds per-input FIFO buffering, valid/ready flow control on every port, and a double-buffered route table: shadow written by CNFG, active updated by LOAD. Each output runs round-robin arbitration among the inputs routed to it. Sits in the NoC tile between the links and the local core interface.

---
 rtl/noc_pkg.sv | 16 +
 rtl/noc_input_fifo.sv | 57 +++++
 rtl/noc_router_buffered.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared defaults and the route-table entry type for the buffered NoC router.
package noc_pkg;

  localparam int NUM_PORTS_DEF  = 4;
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ROUTE_AW       = 3;  // holds any port address up to 8 ports

  typedef struct packed {
    logic [ROUTE_AW-1:0] out_add;
    logic                en;
  } route_t;

  localparam route_t ROUTE_OFF = '{out_add: 3'd0, en: 1'b0};

endpackage

// File: rtl/noc_input_fifo.sv
// Per-input synchronous FIFO; push is refused when full even if a pop occurs
// in the same cycle, so in_ready never depends on the output side.
module noc_input_fifo
  import noc_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int k = 0; k < FIFO_DEPTH; k++) mem_r[k] <= {DATA_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/noc_router_buffered.sv
// Buffered NoC router: per-input FIFOs, double-buffered route table and a
// round-robin arbiter feeding a one-flit register on every output.
module noc_router_buffered
  import noc_pkg::*;
#(
  parameter  int NUM_PORTS  = NUM_PORTS_DEF,
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int ADDR_W     = $clog2(NUM_PORTS)
) (
  input  logic                        CLK,
  input  logic                        RES,
  input  logic                        CS,
  input  logic                        CNFG,
  input  logic                        LOAD,
  input  logic [ADDR_W-1:0]           cfg_in_add,
  input  logic [ADDR_W-1:0]           cfg_out_add,
  input  logic                        cfg_en,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready
);

  localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0]   PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);
  localparam logic [ADDR_W-1:0] LAST_PORT  = ADDR_W'(NUM_PORTS - 1);

  route_t shadow_r [NUM_PORTS];
  route_t active_r [NUM_PORTS];

  logic cfg_wr_s;
  logic cfg_load_s;
  logic cfg_in_ok_s;
  logic cfg_out_ok_s;

  logic [NUM_PORTS*DATA_W-1:0] head_s;
  logic [NUM_PORTS-1:0]        full_s;
  logic [NUM_PORTS-1:0]        empty_s;
  logic [NUM_PORTS-1:0]        push_s;
  logic [NUM_PORTS-1:0]        pop_s;
  logic [NUM_PORTS-1:0]        gnt_valid_s;
  logic [NUM_PORTS*ADDR_W-1:0] gnt_idx_s;

  assign cfg_wr_s     = CS & CNFG;
  assign cfg_load_s   = CS & LOAD;
  assign cfg_in_ok_s  = ({1'b0, cfg_in_add} < PORT_LIMIT);
  assign cfg_out_ok_s = ({1'b0, cfg_out_add} < PORT_LIMIT);

  // Shadow table: an unreachable destination is stored but left disabled.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      for (int i = 0; i < NUM_PORTS; i++) shadow_r[i] <= ROUTE_OFF;
    end else if (cfg_wr_s && cfg_in_ok_s) begin
      shadow_r[cfg_in_add] <= '{out_add: ROUTE_AW'(cfg_out_add),
                                en:      cfg_en & cfg_out_ok_s};
    end
  end

  // Active table samples the shadow before any same-edge write lands.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      for (int i = 0; i < NUM_PORTS; i++) active_r[i] <= ROUTE_OFF;
    end else if (cfg_load_s) begin
      for (int i = 0; i < NUM_PORTS; i++) active_r[i] <= shadow_r[i];
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    logic [CNT_W-1:0] count_s;

    noc_input_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (CLK),
      .rst_n (RES),
      .push  (push_s[i]),
      .wdata (in_data[i*DATA_W +: DATA_W]),
      .pop   (pop_s[i]),
      .rdata (head_s[i*DATA_W +: DATA_W]),
      .full  (full_s[i]),
      .empty (empty_s[i]),
      .count (count_s)
    );

    assign in_ready[i] = (count_s != CNT_W'(FIFO_DEPTH));
  end

  assign push_s = in_valid & ~full_s;

  // An input can be granted by at most one output, so the pops simply OR.
  always_comb begin
    pop_s = {NUM_PORTS{1'b0}};
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pop_s[i] = pop_s[i] |
                   (gnt_valid_s[o] & (gnt_idx_s[o*ADDR_W +: ADDR_W] == ADDR_W'(i)));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0] req_s;
    logic [ADDR_W-1:0]    ptr_r;
    logic [ADDR_W-1:0]    pick_s;
    logic                 found_s;
    logic                 can_grant_s;
    logic                 valid_r;
    logic [DATA_W-1:0]    data_r;

    assign can_grant_s = ~valid_r | out_ready[o];

    // Requests from inputs whose active route points here.
    always_comb begin
      req_s = {NUM_PORTS{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_s[i] = ~empty_s[i] & active_r[i].en &
                   (active_r[i].out_add == ROUTE_AW'(o));
      end
    end

    // Round-robin pick: first requester at or after ptr_r, wrapping.
    always_comb begin
      int idx;
      idx     = 0;
      found_s = 1'b0;
      pick_s  = {ADDR_W{1'b0}};
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = (int'(ptr_r) + k) % NUM_PORTS;
        if (!found_s && can_grant_s && req_s[idx]) begin
          found_s = 1'b1;
          pick_s  = ADDR_W'(idx);
        end else begin
          pick_s  = pick_s;
        end
      end
    end

    // Output register and pointer; data only changes on a new grant.
    always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
        valid_r <= 1'b0;
        data_r  <= {DATA_W{1'b0}};
        ptr_r   <= {ADDR_W{1'b0}};
      end else if (found_s) begin
        valid_r <= 1'b1;
        data_r  <= head_s[pick_s*DATA_W +: DATA_W];
        ptr_r   <= (pick_s == LAST_PORT) ? {ADDR_W{1'b0}} : pick_s + ADDR_W'(1);
      end else if (out_ready[o]) begin
        valid_r <= 1'b0;
      end
    end

    assign gnt_valid_s[o]                   = found_s;
    assign gnt_idx_s[o*ADDR_W +: ADDR_W]    = pick_s;
    assign out_valid[o]                     = valid_r;
    assign out_data[o*DATA_W +: DATA_W]     = data_r;
  end

endmodule
